// File: rtl/sha2_hcu_sched.sv
// SHA-224/256/384/512 compute unit with on-chip message schedule.
// Takes 16 padded words per block, expands W_t internally and emits one truncated digest beat.
module sha2_hcu_sched #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned MODE_POS             = 0,
  parameter int unsigned ERR_POS              = 127
) (
  input  logic                            axis_aclk,
  input  logic                            reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  typedef enum logic [2:0] {StIdle, StLoad, StExpand, StFinal, StDigest} state_e;

  localparam logic [C_M_AXIS_TUSER_WIDTH-1:0] ErrBit =
      {{(C_M_AXIS_TUSER_WIDTH-1){1'b0}}, 1'b1} << ERR_POS;

  // 32-bit round constants are the upper halves of the 64-bit table.
  localparam logic [63:0] KTab [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [63:0] IvTab [4][8] = '{
    '{64'hc1059ed8, 64'h367cd507, 64'h3070dd17, 64'hf70e5939,
      64'hffc00b31, 64'h68581511, 64'h64f98fa7, 64'hbefa4fa4},
    '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
      64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19},
    '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4},
    '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179}
  };

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] bsig0(input logic [63:0] x, input logic wide);
    if (wide) return rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
    return {32'h0, rotr32(x[31:0], 2) ^ rotr32(x[31:0], 13) ^ rotr32(x[31:0], 22)};
  endfunction

  function automatic logic [63:0] bsig1(input logic [63:0] x, input logic wide);
    if (wide) return rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
    return {32'h0, rotr32(x[31:0], 6) ^ rotr32(x[31:0], 11) ^ rotr32(x[31:0], 25)};
  endfunction

  function automatic logic [63:0] ssig0(input logic [63:0] x, input logic wide);
    if (wide) return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
    return {32'h0, rotr32(x[31:0], 7) ^ rotr32(x[31:0], 18) ^ (x[31:0] >> 3)};
  endfunction

  function automatic logic [63:0] ssig1(input logic [63:0] x, input logic wide);
    if (wide) return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
    return {32'h0, rotr32(x[31:0], 17) ^ rotr32(x[31:0], 19) ^ (x[31:0] >> 10)};
  endfunction

  state_e state_q, state_d;
  logic [6:0]  rnd_q;
  logic [1:0]  mode_q;
  logic        blk_last_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  dig_q;
  logic [63:0] hv_q [8];
  logic [63:0] rv_q [8];
  logic [63:0] wv_q [16];

  logic        wide;
  logic [6:0]  rmax;
  logic [1:0]  mode_in;
  logic [63:0] msk, w_in, w_exp, w_t, k_t, ch, maj, t1, t2;
  logic [63:0] rv_nxt [8];
  logic [63:0] sum [8];
  logic [C_M_AXIS_DATA_WIDTH-1:0] dig_pack;

  assign wide    = mode_q[1];
  assign rmax    = wide ? 7'd79 : 7'd63;
  assign mode_in = s_axis_tuser[MODE_POS +: 2];
  assign msk     = wide ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;

  // Round datapath: a..h live in rv_q[0..7]; W ring holds W[t-16] at index 0.
  always_comb begin
    w_in  = wide ? s_axis_tdata : {32'h0, s_axis_tdata[31:0]};
    w_exp = (ssig1(wv_q[14], wide) + wv_q[9] + ssig0(wv_q[1], wide) + wv_q[0]) & msk;
    w_t   = (state_q == StLoad) ? w_in : w_exp;
    k_t   = wide ? KTab[rnd_q] : {32'h0, KTab[rnd_q][63:32]};
    ch    = (rv_q[4] & rv_q[5]) ^ (~rv_q[4] & rv_q[6]);
    maj   = (rv_q[0] & rv_q[1]) ^ (rv_q[0] & rv_q[2]) ^ (rv_q[1] & rv_q[2]);
    t1    = (rv_q[7] + bsig1(rv_q[4], wide) + ch + k_t + w_t) & msk;
    t2    = (bsig0(rv_q[0], wide) + maj) & msk;
    rv_nxt[0] = (t1 + t2) & msk;
    rv_nxt[1] = rv_q[0];
    rv_nxt[2] = rv_q[1];
    rv_nxt[3] = rv_q[2];
    rv_nxt[4] = (rv_q[3] + t1) & msk;
    rv_nxt[5] = rv_q[4];
    rv_nxt[6] = rv_q[5];
    rv_nxt[7] = rv_q[6];
    for (int i = 0; i < 8; i++) begin
      sum[i] = (hv_q[i] + rv_q[i]) & msk;
    end
  end

  always_comb begin
    dig_pack = '0;
    unique case (mode_q)
      2'b11: dig_pack = {sum[0], sum[1], sum[2], sum[3], sum[4], sum[5], sum[6], sum[7]};
      2'b10: dig_pack = {sum[0], sum[1], sum[2], sum[3], sum[4], sum[5], 128'h0};
      2'b01: dig_pack = {sum[0][31:0], sum[1][31:0], sum[2][31:0], sum[3][31:0],
                         sum[4][31:0], sum[5][31:0], sum[6][31:0], sum[7][31:0], 256'h0};
      default: dig_pack = {sum[0][31:0], sum[1][31:0], sum[2][31:0], sum[3][31:0],
                           sum[4][31:0], sum[5][31:0], sum[6][31:0], 288'h0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (s_axis_tvalid) state_d = StLoad;
      StLoad: begin
        if (s_axis_tvalid) begin
          if (rnd_q == 7'd15)    state_d = StExpand;
          else if (s_axis_tlast) state_d = StDigest;
        end
      end
      StExpand: if (rnd_q == rmax) state_d = StFinal;
      StFinal:  state_d = blk_last_q ? StDigest : StLoad;
      StDigest: if (m_axis_tready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge axis_aclk) begin
    if (reset) begin
      rnd_q      <= '0;
      mode_q     <= '0;
      blk_last_q <= 1'b0;
      tuser_q    <= '0;
      dig_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        hv_q[i] <= '0;
        rv_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) wv_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axis_tvalid) begin
            mode_q     <= mode_in;
            tuser_q    <= s_axis_tuser & ~ErrBit;
            blk_last_q <= 1'b0;
            rnd_q      <= '0;
            for (int i = 0; i < 8; i++) begin
              hv_q[i] <= IvTab[mode_in][i];
              rv_q[i] <= IvTab[mode_in][i];
            end
          end
        end
        StLoad: begin
          if (s_axis_tvalid) begin
            rv_q <= rv_nxt;
            for (int i = 0; i < 15; i++) wv_q[i] <= wv_q[i+1];
            wv_q[15] <= w_t;
            rnd_q    <= rnd_q + 7'd1;
            if (rnd_q == 7'd15) begin
              blk_last_q <= s_axis_tlast;
            end else if (s_axis_tlast) begin
              // Short block: abandon it and report an empty, flagged digest.
              tuser_q[ERR_POS] <= 1'b1;
              dig_q            <= '0;
              rnd_q            <= '0;
            end
          end
        end
        StExpand: begin
          rv_q <= rv_nxt;
          for (int i = 0; i < 15; i++) wv_q[i] <= wv_q[i+1];
          wv_q[15] <= w_t;
          rnd_q    <= (rnd_q == rmax) ? 7'd0 : rnd_q + 7'd1;
        end
        StFinal: begin
          hv_q  <= sum;
          rv_q  <= sum;
          rnd_q <= '0;
          if (blk_last_q) dig_q <= dig_pack;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready = (state_q == StLoad);
  assign m_axis_tvalid = (state_q == StDigest);
  assign m_axis_tlast  = (state_q == StDigest);
  assign m_axis_tdata  = dig_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_sha2_hcu_sched.sv
// Directed bench for sha2_hcu_sched: known-answer digests, latency, backpressure,
// short-block error and mid-message reset.
module tb_sha2_hcu_sched;

  localparam logic [511:0] E256 =
    {256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 256'h0};
  localparam logic [511:0] E224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 288'h0};
  localparam logic [511:0] E384 =
    {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7,
     128'h0};
  localparam logic [511:0] E512 =
    512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0] E256_2 =
    {256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 256'h0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  s_tdata = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic         s_tlast = 1'b0;
  logic [511:0] m_tdata;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0] msg_w [32];
  bit          msg_l [32];

  sha2_hcu_sched dut (
    .axis_aclk     (clk),
    .reset         (reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_abc(input bit wide, input logic [31:0] junk);
    for (int i = 0; i < 32; i++) begin
      msg_w[i] = wide ? 64'h0 : {junk, 32'h0};
      msg_l[i] = 1'b0;
    end
    msg_w[0]  = wide ? 64'h6162638000000000 : {junk, 32'h61626380};
    msg_w[15] = wide ? 64'h18 : {junk, 32'h18};
    msg_l[15] = 1'b1;
  endtask

  // Presents words in order; each waits for its handshake with a bounded loop.
  task automatic send_words(input int n, input logic [127:0] tu, input bit bubbles);
    int guard;
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (bubbles && ($urandom_range(0, 2) == 0)) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      s_tdata  = msg_w[i];
      s_tlast  = msg_l[i];
      s_tuser  = tu;
      s_tvalid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 400) begin
        acc = s_tready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_word%0d accepted=0 required=1", i);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_digest(output bit got, output int at_cyc);
    got = 1'b0;
    at_cyc = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_tvalid) begin
        got = 1'b1;
        at_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); end
    checks++; if (m_tdata !== 512'h0) begin errors++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tuser !== 128'h0) begin errors++; $display("FAIL rst_m_tuser got=%h exp=0", m_tuser); end
  endtask

  task automatic test_sha256_abc;
    logic [127:0] tu, etu;
    bit got;
    int at, c0;
    tu = {4{32'h8badf00d}};
    tu[1:0] = 2'b01;
    etu = tu;
    etu[127] = 1'b0;
    set_abc(1'b0, 32'h0);
    c0 = cyc;
    send_words(16, tu, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || (at - c0) != 66) begin
      errors++; $display("FAIL sha256_latency got=%0d (seen=%0b) exp=66", at - c0, got);
    end
    checks++; if (m_tdata !== E256) begin errors++; $display("FAIL sha256_tdata got=%h exp=%h", m_tdata, E256); end
    checks++; if (m_tuser !== etu) begin errors++; $display("FAIL sha256_tuser got=%h exp=%h", m_tuser, etu); end
    checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL sha256_tlast got=%b exp=1", m_tlast); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL sha256_drop got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_sha512_abc(input string tag);
    logic [127:0] tu;
    bit got;
    int at, c0;
    tu = 128'h3;
    set_abc(1'b1, 32'h0);
    c0 = cyc;
    send_words(16, tu, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || (at - c0) != 82) begin
      errors++; $display("FAIL %s_latency got=%0d (seen=%0b) exp=82", tag, at - c0, got);
    end
    checks++; if (m_tdata !== E512) begin errors++; $display("FAIL %s_tdata got=%h exp=%h", tag, m_tdata, E512); end
    @(posedge clk); #1;
  endtask

  task automatic test_sha224_abc;
    bit got;
    int at;
    set_abc(1'b0, 32'hcafef00d);
    send_words(16, 128'h0, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || m_tdata !== E224) begin
      errors++; $display("FAIL sha224_tdata got=%h (seen=%0b) exp=%h", m_tdata, got, E224);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sha384_abc;
    bit got;
    int at;
    set_abc(1'b1, 32'h0);
    send_words(16, 128'h2, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || m_tdata !== E384) begin
      errors++; $display("FAIL sha384_tdata got=%h (seen=%0b) exp=%h", m_tdata, got, E384);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_two_block_backpressure;
    bit got, stable;
    int at;
    logic [7:0] c;
    for (int i = 0; i < 32; i++) begin
      msg_w[i] = 64'h0;
      msg_l[i] = 1'b0;
    end
    for (int i = 0; i < 14; i++) begin
      c = 8'h61 + 8'(i);
      msg_w[i] = {32'h0, c, c + 8'd1, c + 8'd2, c + 8'd3};
    end
    msg_w[14] = 64'h80000000;
    msg_w[31] = 64'h1c0;
    msg_l[31] = 1'b1;
    m_tready = 1'b0;
    send_words(32, 128'h1, 1'b1);
    wait_digest(got, at);
    checks++;
    if (!got || m_tdata !== E256_2) begin
      errors++; $display("FAIL two_block_tdata got=%h (seen=%0b) exp=%h", m_tdata, got, E256_2);
    end
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_tvalid !== 1'b1 || m_tdata !== E256_2 || s_tready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable got tvalid=%b s_tready=%b tdata=%h exp tvalid=1 s_tready=0 tdata=%h",
               m_tvalid, s_tready, m_tdata, E256_2);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_short_block_error;
    logic [127:0] tu, etu;
    bit got;
    int at;
    tu = 128'h0123456789abcdef0011223344556601;
    etu = tu;
    etu[127] = 1'b1;
    set_abc(1'b0, 32'h0);
    msg_l[7] = 1'b1;
    send_words(8, tu, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || m_tdata !== 512'h0) begin
      errors++; $display("FAIL err_tdata got=%h (seen=%0b) exp=0", m_tdata, got);
    end
    checks++; if (m_tuser !== etu) begin errors++; $display("FAIL err_tuser got=%h exp=%h", m_tuser, etu); end
    @(posedge clk); #1;
    set_abc(1'b0, 32'h0);
    send_words(16, 128'h1, 1'b0);
    wait_digest(got, at);
    checks++;
    if (!got || m_tdata !== E256) begin
      errors++; $display("FAIL err_recover got=%h (seen=%0b) exp=%h", m_tdata, got, E256);
    end
    checks++;
    if (m_tuser[127] !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", m_tuser[127]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_expand;
    bit quiet;
    set_abc(1'b0, 32'h0);
    send_words(16, 128'h1, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_tready got=%b exp=0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_tvalid got=%b exp=0", m_tvalid); end
    quiet = 1'b1;
    repeat (80) begin
      @(posedge clk); #1;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL mid_rst_discard got=active exp=idle"); end
    test_sha512_abc("post_reset_sha512");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_sha256_abc();
    test_sha512_abc("sha512");
    test_sha224_abc();
    test_sha384_abc();
    test_two_block_backpressure();
    test_short_block_error();
    test_reset_in_expand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
